// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, forwarding-source selector and default datapath width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_t;

endpackage

// File: rtl/fwd_select.sv
// Picks the newest value of one source register: EX/MEM result, then MEM/WB result, else latched data.
module fwd_select
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] data,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output fwd_sel_t        sel,
    output logic [XLEN-1:0] value
);

    // x0 is hardwired zero, so a pending write to it must never be forwarded.
    always_comb begin
        sel   = FWD_REG;
        value = data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel   = FWD_EXMEM;
            value = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel   = FWD_MEMWB;
            value = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and ALU operand select.
module id_ex_stage #(
    parameter int XLEN = alu_pkg::XLEN_DEFAULT,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_src_a,
    input  logic            id_src_b,
    input  logic [3:0]      id_aluop,
    input  logic            id_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_aluop,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_store_data
);
    import alu_pkg::*;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs2_q;
    logic [RA_W-1:0] rd_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic            src_a_q;
    logic            src_b_q;
    logic [3:0]      aluop_q;
    logic            reg_write_q;

    fwd_sel_t        sel_rs1;
    fwd_sel_t        sel_rs2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    fwd_select #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs              (rs1_q),
        .data            (rs1_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .sel             (sel_rs1),
        .value           (fwd_rs1)
    );

    fwd_select #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs              (rs2_q),
        .data            (rs2_data_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .sel             (sel_rs2),
        .value           (fwd_rs2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            src_a_q     <= 1'b0;
            src_b_q     <= 1'b0;
            aluop_q     <= '0;
            reg_write_q <= 1'b0;
        end else if (stall) begin
            // Capture results retiring while held so they are not lost once the forwarder moves on.
            if (sel_rs1 != FWD_REG) rs1_data_q <= fwd_rs1;
            if (sel_rs2 != FWD_REG) rs2_data_q <= fwd_rs2;
        end else begin
            valid_q     <= id_valid;
            pc_q        <= id_pc;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            src_a_q     <= id_src_a;
            src_b_q     <= id_src_b;
            aluop_q     <= id_aluop;
            reg_write_q <= id_reg_write & id_valid;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_a          = src_a_q ? pc_q : fwd_rs1;
    assign ex_b          = src_b_q ? imm_q : fwd_rs2;
    assign ex_aluop      = aluop_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against a field-level model of the EX slot.
module tb_id_ex_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, stall, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_src_a, id_src_b, id_reg_write;
    logic [3:0]  id_aluop;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_aluop;
    logic [4:0]  ex_rd;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        sa, sb;
        logic [3:0]  op;
        logic        rw;
    } ex_t;

    ex_t m;

    logic [3:0] ops [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                             ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_aluop(id_aluop),
        .id_reg_write(id_reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Newest architectural value of register r given the current forward sources.
    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_result;
        return d;
    endfunction

    task automatic model_edge();
        if (flush) m = '0;
        else if (stall) begin
            m.d1 = newest(m.rs1, m.d1);
            m.d2 = newest(m.rs2, m.d2);
        end else begin
            m.valid = id_valid;
            m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
            m.sa = id_src_a; m.sb = id_src_b; m.op = id_aluop;
            m.rw = id_reg_write && id_valid;
        end
    endtask

    task automatic check_all(input string tag);
        chk_val({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
        chk_val({tag, ".a"},     ex_a, m.sa ? m.pc : newest(m.rs1, m.d1));
        chk_val({tag, ".b"},     ex_b, m.sb ? m.imm : newest(m.rs2, m.d2));
        chk_val({tag, ".op"},    32'(ex_aluop), 32'(m.op));
        chk_val({tag, ".rd"},    32'(ex_rd), 32'(m.rd));
        chk_val({tag, ".rw"},    32'(ex_reg_write), 32'(m.rw));
        chk_val({tag, ".st"},    ex_store_data, newest(m.rs2, m.d2));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic sa, input logic sb,
                          input logic [3:0] op, input logic rw);
        id_valid = v; id_rs1 = r1; id_rs1_data = d1; id_rs2 = r2; id_rs2_data = d2;
        id_rd = rd; id_imm = imm; id_src_a = sa; id_src_b = sb; id_aluop = op;
        id_reg_write = rw; id_pc = 32'h100;
    endtask

    task automatic no_fwd();
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    initial begin
        rst = 1'b1; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0);
        no_fwd();
        m = '0;
        repeat (2) @(posedge clk);
        #1; check_all("reset");
        chk_val("reset.a_zero", ex_a, 32'd0);
        rst = 1'b0;

        // Basic latch, one-cycle latency.
        set_id(1, 5'd1, 32'd7, 5'd2, 32'd0, 5'd3, 32'd5, 0, 1, ALU_ADD, 1);
        step("latch");
        chk_val("latch.a7", ex_a, 32'd7);
        chk_val("latch.b5", ex_b, 32'd5);
        chk_val("latch.rw", 32'(ex_reg_write), 32'd1);

        // Forwarding priority on rs1.
        set_id(1, 5'd4, 32'd1, 5'd9, 32'd3, 5'd8, 32'd0, 0, 0, ALU_SUB, 1);
        step("fwd_latch");
        exmem_rd = 4; exmem_reg_write = 1; exmem_result = 10;
        memwb_rd = 4; memwb_reg_write = 1; memwb_result = 20;
        #1; chk_val("fwd.exmem", ex_a, 32'd10); check_all("fwd1");
        exmem_reg_write = 0;
        #1; chk_val("fwd.memwb", ex_a, 32'd20); check_all("fwd2");
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1; chk_val("fwd.none", ex_a, 32'd1); check_all("fwd3");

        // x0 is never forwarded.
        no_fwd();
        set_id(1, 5'd1, 32'd4, 5'd0, 32'd0, 5'd2, 32'd0, 0, 0, ALU_OR, 1);
        step("x0_latch");
        exmem_rd = 0; exmem_reg_write = 1; exmem_result = 99;
        #1; chk_val("x0.b", ex_b, 32'd0); chk_val("x0.st", ex_store_data, 32'd0);

        // Stall refresh keeps a value that retires while EX is held.
        no_fwd();
        set_id(1, 5'd6, 32'd2, 5'd7, 32'd0, 5'd5, 32'd0, 0, 0, ALU_XOR, 1);
        step("sr_latch");
        stall = 1; memwb_rd = 6; memwb_reg_write = 1; memwb_result = 55;
        set_id(1, 5'd11, 32'd77, 5'd12, 32'd88, 5'd13, 32'd1, 0, 0, ALU_AND, 1);
        step("sr_hold1");
        memwb_rd = 9; memwb_result = 66;
        step("sr_hold2");
        chk_val("sr.a55", ex_a, 32'd55);
        stall = 0; no_fwd();
        step("sr_release");
        chk_val("sr.new_a", ex_a, 32'd77);

        // Flush beats stall; invalid slot never writes.
        stall = 1; flush = 1;
        step("flush_stall");
        chk_val("flush.valid", 32'(ex_valid), 32'd0);
        chk_val("flush.rw", 32'(ex_reg_write), 32'd0);
        stall = 0; flush = 0;
        set_id(0, 5'd1, 32'd3, 5'd2, 32'd4, 5'd5, 32'd0, 0, 0, ALU_ADD, 1);
        step("bubble");
        chk_val("bubble.rw", 32'(ex_reg_write), 32'd0);

        // Async reset mid-cycle, no edge needed.
        set_id(1, 5'd1, 32'd9, 5'd2, 32'd8, 5'd4, 32'd6, 1, 1, ALU_SRA, 1);
        step("pre_rst");
        stall = 1;
        #3 rst = 1'b1; m = '0;
        #1; check_all("async_rst");
        chk_val("async_rst.b", ex_b, 32'd0);
        #1 rst = 1'b0; stall = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                   5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)), $urandom(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
            id_pc = $urandom();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_result = $urandom();
            memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_result = $urandom();
            step("rand");
            exmem_rd = 5'($urandom_range(0, 7)); memwb_rd = 5'($urandom_range(0, 7));
            #1; check_all("rand_comb");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
